// File: rtl/mul_div_pkg.sv
// ============================================================================
// Module   : mul_div_pkg
// Brief    : Shared widths, state encoding and constants for the mul/div pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int PR_W       = DIVISOR_W + 1;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [DIVIDEND_W-1:0] DIV0_QUOTIENT = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/div_step_u08.sv
// ============================================================================
// Module   : div_step_u08
// Brief    : One combinational restoring-division step (one quotient bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step_u08
  import mul_div_pkg::*;
(
  input  logic [PR_W-1:0]      pr_in,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [PR_W-1:0]      pr_out,
  output logic                 qbit
);

  logic [PR_W-1:0] trial;

  // The shifted trial value keeps all 9 bits: with divisor >= 0x80 it can
  // exceed 255. pr_in's top bit is always clear while pr < divisor.
  always_comb begin
    trial  = {pr_in[PR_W-2:0], dividend_bit};
    qbit   = pr_in[PR_W-1] | (trial >= {1'b0, divisor});
    pr_out = qbit ? (trial - {1'b0, divisor}) : trial;
  end

endmodule

`default_nettype wire

// File: rtl/seq_div_u16_u08.sv
// ============================================================================
// Module   : seq_div_u16_u08
// Brief    : Sequential unsigned 16/8 restoring divider, one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_div_u16_u08
  import mul_div_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);

  if ((1 << CNT_W) <= DIVIDEND_W) begin : g_cnt_w_check
    $error("CNT_W too narrow for DIVIDEND_W iterations");
  end

  div_state_t             state;
  div_state_t             state_next;
  logic [DIVIDEND_W-1:0]  dq;
  logic [DIVISOR_W-1:0]   dvs;
  logic [PR_W-1:0]        pr;
  logic [PR_W-1:0]        step_pr;
  logic                   step_qbit;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;

  assign accept = (state == IDLE) && start;

  div_step_u08 u_step (
    .pr_in        (pr),
    .dividend_bit (dq[DIVIDEND_W-1]),
    .divisor      (dvs),
    .pr_out       (step_pr),
    .qbit         (step_qbit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == '0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  // dq starts as the dividend and fills with quotient bits from the LSB;
  // result registers change only on the transition into DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dq        <= '0;
      dvs       <= '0;
      pr        <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      dq  <= dividend;
      dvs <= divisor;
      pr  <= '0;
      if (divisor == '0) begin
        cnt       <= '0;
        quotient  <= DIV0_QUOTIENT;
        remainder <= dividend[DIVISOR_W-1:0];
        div_zero  <= 1'b1;
      end else begin
        cnt <= CNT_W'(DIVIDEND_W - 1);
      end
    end else if (state == RUN) begin
      pr <= step_pr;
      dq <= {dq[DIVIDEND_W-2:0], step_qbit};
      if (cnt == '0) begin
        quotient  <= {dq[DIVIDEND_W-2:0], step_qbit};
        remainder <= step_pr[DIVISOR_W-1:0];
        div_zero  <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_div_u16_u08.sv
// ============================================================================
// Module   : tb_seq_div_u16_u08
// Brief    : Self-checking bench for seq_div_u16_u08 with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_div_u16_u08;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  seq_div_u16_u08 dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<2ms", $time);
    $fatal(1);
  end

  // Reference model: plain integer arithmetic; zero divisor yields all-ones.
  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r, output int dz);
    if (b == 0) begin
      q = 16'hFFFF; r = a & 8'hFF; dz = 1;
    end else begin
      q = a / b; r = a % b; dz = 0;
    end
  endfunction

  // Issues one operation from IDLE and waits for done (lat=0 on timeout).
  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       output int lat, output int busy_cyc,
                       output logic [15:0] q, output logic [7:0] r, output logic dz);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock); #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    busy_cyc = 0;
    for (int n = 1; n <= 40; n++) begin
      if (busy) busy_cyc++;
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clock); #1;
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; dividend = 16'h1234; divisor = 8'h56;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_zero} !== 27'd0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b done=%b q=%h r=%h dz=%b, required all 0",
               busy, done, quotient, remainder, div_zero);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_zero} !== 27'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b q=%h r=%h dz=%b, required all 0",
               busy, done, quotient, remainder, div_zero);
    end
  endtask

  task automatic test_basic;
    int lat, bc;
    logic [15:0] q; logic [7:0] r; logic dz;
    do_op(16'd1000, 8'd7, lat, bc, q, r, dz);
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL basic_latency: got %0d required 17", lat); end
    checks++;
    if (bc !== 17) begin errors++; $display("FAIL basic_busy_cycles: got %0d required 17", bc); end
    checks++;
    if ({q, r, dz} !== {16'd142, 8'd6, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b required q=142 r=6 dz=0", q, r, dz);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_back_to_idle: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_corners;
    logic [15:0] a_tab [3] = '{16'hFFFF, 16'hFFFF, 16'd12345};
    logic [7:0]  b_tab [3] = '{8'hFF, 8'd1, 8'd200};
    logic [15:0] q_tab [3] = '{16'd257, 16'hFFFF, 16'd61};
    logic [7:0]  r_tab [3] = '{8'd0, 8'd0, 8'd145};
    int lat, bc;
    logic [15:0] q; logic [7:0] r; logic dz;
    for (int i = 0; i < 3; i++) begin
      do_op(a_tab[i], b_tab[i], lat, bc, q, r, dz);
      checks++;
      if (lat !== 17 || {q, r, dz} !== {q_tab[i], r_tab[i], 1'b0}) begin
        errors++;
        $display("FAIL corner_%0d: got lat=%0d q=%0d r=%0d dz=%b required lat=17 q=%0d r=%0d dz=0",
                 i, lat, q, r, dz, q_tab[i], r_tab[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bc;
    logic [15:0] q; logic [7:0] r; logic dz;
    do_op(16'd5, 8'd0, lat, bc, q, r, dz);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d required 1", lat); end
    checks++;
    if ({q, r, dz} !== {16'hFFFF, 8'd5, 1'b1}) begin
      errors++;
      $display("FAIL div0_result: got q=%h r=%0d dz=%b required q=ffff r=5 dz=1", q, r, dz);
    end
    do_op(16'd10, 8'd3, lat, bc, q, r, dz);
    checks++;
    if (lat !== 17 || {q, r, dz} !== {16'd3, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL div0_recover: got lat=%0d q=%0d r=%0d dz=%b required lat=17 q=3 r=1 dz=0",
               lat, q, r, dz);
    end
  endtask

  task automatic test_start_while_busy;
    int done_cnt = 0;
    int done_at = 0;
    int unstable = 0;
    dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 5 || n == 17) begin
        start = 1'b1; dividend = 16'd50; divisor = 8'd5;
      end else begin
        start = 1'b0;
      end
      if (done) begin done_cnt++; done_at = n; end
      if (n > 17 && (quotient !== 16'd142 || remainder !== 8'd6 || busy !== 1'b0)) unstable++;
      @(posedge clock); #1;
    end
    start = 1'b0;
    checks++;
    if (done_cnt !== 1 || done_at !== 17) begin
      errors++;
      $display("FAIL busy_start_done: got %0d dones last at %0d required 1 done at 17",
               done_cnt, done_at);
    end
    checks++;
    if ({quotient, remainder, div_zero} !== {16'd142, 8'd6, 1'b0} || unstable !== 0) begin
      errors++;
      $display("FAIL busy_start_result: got q=%0d r=%0d dz=%b unstable=%0d required q=142 r=6 dz=0 unstable=0",
               quotient, remainder, div_zero, unstable);
    end
  endtask

  task automatic test_reset_mid_op;
    int done_seen = 0;
    int lat, bc;
    logic [15:0] q; logic [7:0] r; logic dz;
    dividend = 16'd40000; divisor = 8'd200; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int n = 1; n < 8; n++) begin
      if (done) done_seen++;
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_zero} !== 27'd0) begin
      errors++;
      $display("FAIL midreset_clear: got busy=%b done=%b q=%h r=%h dz=%b required all 0",
               busy, done, quotient, remainder, div_zero);
    end
    for (int n = 0; n < 3; n++) begin
      @(posedge clock); #1;
      if (done) done_seen++;
    end
    reset_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clock); #1;
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d done cycles required 0", done_seen);
    end
    do_op(16'd40000, 8'd200, lat, bc, q, r, dz);
    checks++;
    if (lat !== 17 || {q, r, dz} !== {16'd200, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_rerun: got lat=%0d q=%0d r=%0d dz=%b required lat=17 q=200 r=0 dz=0",
               lat, q, r, dz);
    end
  endtask

  task automatic test_random;
    int lat, bc, eq, er, ez, a, b;
    logic [15:0] q; logic [7:0] r; logic dz;
    for (int i = 0; i < 2000; i++) begin
      a = int'($urandom_range(0, 65535));
      if (i % 50 == 49)     b = 0;
      else if (i % 4 == 0)  b = int'($urandom_range(128, 255));
      else                  b = int'($urandom_range(1, 255));
      ref_div(a, b, eq, er, ez);
      do_op(16'(a), 8'(b), lat, bc, q, r, dz);
      checks++;
      if (int'(q) != eq || int'(r) != er || int'(dz) != ez || lat != ((b == 0) ? 1 : 17)) begin
        errors++;
        $display("FAIL random_model %0d/%0d: got q=%0d r=%0d dz=%b lat=%0d required q=%0d r=%0d dz=%0d",
                 a, b, q, r, dz, lat, eq, er, ez);
      end
      if (b != 0) begin
        checks++;
        if (int'(q) * b + int'(r) != a || int'(r) >= b) begin
          errors++;
          $display("FAIL random_invariant %0d/%0d: got q=%0d r=%0d required q*d+r=dividend and r<d",
                   a, b, q, r);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
